// File: rtl/uart_bus_arbiter_pkg.sv
// Shared FSM encoding and uart_control register constants for the UART bus arbiter.
// Line lock support is compiled in when UART_ARB_LINE_LOCK_EN is defined.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE_WR = 2'd1,
      ST_ISSUE_RD = 2'd2,
      ST_WAIT_RD  = 2'd3
   } arb_state_e;

   localparam logic [3:0] THR_OFF = 4'h1;
   localparam logic [3:0] RBR_OFF = 4'h0;
   localparam logic [7:0] LF      = 8'h0A;

   // Word offset decode of the uart_control register map
   function automatic logic is_thr(input logic [31:0] addr);
      return addr[5:2] == THR_OFF;
   endfunction

endpackage

// File: rtl/uart_bus_arbiter_if.sv
// Requester-side and uart_control-side signals of the UART bus arbiter.
// slave = arbiter view, master = view of the surrounding masters and uart_control.
interface uart_bus_arbiter_if #(
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ*32-1:0] req_addr_i;
   logic [NUM_REQ-1:0]    req_wren_i;
   logic [NUM_REQ-1:0]    req_rden_i;
   logic [NUM_REQ*32-1:0] req_din_i;
   logic [NUM_REQ-1:0]    req_ready_o;
   logic [NUM_REQ-1:0]    req_dout_valid_o;
   logic [31:0]           req_dout_o;
   logic                  rd_timeout_o;
   logic [31:0]           uart_addr_o;
   logic                  uart_wren_o;
   logic                  uart_rden_o;
   logic [31:0]           uart_din_o;
   logic                  uart_dout_valid_i;
   logic [31:0]           uart_dout_i;
   logic [NUM_REQ-1:0]    grant_o;

   modport slave (
      input  req_addr_i, req_wren_i, req_rden_i, req_din_i,
      input  uart_dout_valid_i, uart_dout_i,
      output req_ready_o, req_dout_valid_o, req_dout_o, rd_timeout_o,
      output uart_addr_o, uart_wren_o, uart_rden_o, uart_din_o, grant_o
   );

   modport master (
      output req_addr_i, req_wren_i, req_rden_i, req_din_i,
      output uart_dout_valid_i, uart_dout_i,
      input  req_ready_o, req_dout_valid_o, req_dout_o, rd_timeout_o,
      input  uart_addr_o, uart_wren_o, uart_rden_o, uart_din_o, grant_o
   );
endinterface

// File: rtl/uart_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or above ptr_i, wrapping.
// Returns the winner one-hot and as an index.
module uart_rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic [N-1:0]     mask_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);
   logic [N-1:0]     elig;
   logic [IDX_W-1:0] idx;

   assign elig = req_i & mask_i;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_o = 1'b0;
      idx     = '0;
      for (int i = 0; i < N; i++) begin
         idx = IDX_W'((int'(ptr_i) + i) % N);
         if (!found_o && elig[idx]) begin
            gnt_o[idx] = 1'b1;
            idx_o      = idx;
            found_o    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares one uart_control register port among NUM_REQ masters, one transaction at a time.
// Define UART_ARB_LINE_LOCK_EN to keep a master's THR line together until LF, LOCK_MAX or LOCK_IDLE.
module uart_bus_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int RD_TIMEOUT = 16,
   parameter int LOCK_MAX   = 128,
   parameter int LOCK_IDLE  = 64
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   uart_bus_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

   logic [31:0] req_addr [NUM_REQ];
   logic [31:0] req_din  [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_addr[gi] = bus.req_addr_i[32*gi +: 32];
      assign req_din[gi]  = bus.req_din_i[32*gi +: 32];
   end

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        din_q, din_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] dvalid_q, dvalid_d;
   logic [31:0]        dout_q, dout_d;
   logic               tout_q, tout_d;
   logic               wren_q, wren_d;
   logic               rden_q, rden_d;
   logic [TMR_W-1:0]   timer_q, timer_d;

   logic [NUM_REQ-1:0] pick_mask, pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_found;
   logic [31:0]        pick_addr, pick_din;

`ifdef UART_ARB_LINE_LOCK_EN
   localparam int LCNT_W = $clog2(LOCK_MAX + 1);
   localparam int ICNT_W = $clog2(LOCK_IDLE + 1);

   logic               lock_q, lock_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [LCNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [ICNT_W-1:0]  idle_cnt_q, idle_cnt_d;

   assign pick_mask = lock_q ? (NUM_REQ'(1) << owner_q) : '1;
`else
   assign pick_mask = '1;
`endif

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] k);
      return (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
   endfunction

   uart_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i   (bus.req_wren_i | bus.req_rden_i),
      .ptr_i   (ptr_q),
      .mask_i  (pick_mask),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   assign pick_addr = req_addr[pick_idx];
   assign pick_din  = req_din[pick_idx];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      din_d    = din_q;
      ready_d  = '0;
      grant_d  = grant_q;
      dvalid_d = '0;
      dout_d   = dout_q;
      tout_d   = 1'b0;
      wren_d   = 1'b0;
      rden_d   = 1'b0;
      timer_d  = timer_q;

      unique case (state_q)
         ST_IDLE: begin
            grant_d = pick_found ? pick_gnt : '0;
            if (pick_found) begin
               ready_d = pick_gnt;
               addr_d  = pick_addr;
               din_d   = pick_din;
               ptr_d   = next_ptr(pick_idx);
               state_d = bus.req_rden_i[pick_idx] ? ST_ISSUE_RD : ST_ISSUE_WR;
            end
         end
         ST_ISSUE_WR: begin
            wren_d  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ISSUE_RD: begin
            rden_d  = 1'b1;
            timer_d = '0;
            state_d = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            if (bus.uart_dout_valid_i) begin
               dout_d   = bus.uart_dout_i;
               dvalid_d = grant_q;
               state_d  = ST_IDLE;
            end else if (timer_q == TMR_W'(RD_TIMEOUT - 1)) begin
               dout_d   = '0;
               dvalid_d = grant_q;
               tout_d   = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef UART_ARB_LINE_LOCK_EN
      lock_d     = lock_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      idle_cnt_d = idle_cnt_q;
      if (state_q == ST_IDLE) begin
         if (pick_found) begin
            idle_cnt_d = '0;
            // Only THR writes move the lock; reads and other registers leave it alone
            if (!bus.req_rden_i[pick_idx] && is_thr(pick_addr)) begin
               if (pick_din[7:0] == LF ||
                   (lock_q && lock_cnt_q == LCNT_W'(LOCK_MAX - 1))) begin
                  lock_d     = 1'b0;
                  lock_cnt_d = '0;
               end else if (!lock_q) begin
                  lock_d     = 1'b1;
                  owner_d    = pick_idx;
                  lock_cnt_d = LCNT_W'(1);
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end
         end else if (lock_q) begin
            if (idle_cnt_q == ICNT_W'(LOCK_IDLE - 1)) begin
               lock_d     = 1'b0;
               lock_cnt_d = '0;
               idle_cnt_d = '0;
               ptr_d      = next_ptr(owner_q);
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         addr_q   <= '0;
         din_q    <= '0;
         ready_q  <= '0;
         grant_q  <= '0;
         dvalid_q <= '0;
         dout_q   <= '0;
         tout_q   <= 1'b0;
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         ready_q  <= ready_d;
         grant_q  <= grant_d;
         dvalid_q <= dvalid_d;
         dout_q   <= dout_d;
         tout_q   <= tout_d;
         wren_q   <= wren_d;
         rden_q   <= rden_d;
         timer_q  <= timer_d;
      end
   end

`ifdef UART_ARB_LINE_LOCK_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lock_q     <= 1'b0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         lock_q     <= lock_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end
`endif

   assign bus.req_ready_o      = ready_q;
   assign bus.req_dout_valid_o = dvalid_q;
   assign bus.req_dout_o       = dout_q;
   assign bus.rd_timeout_o     = tout_q;
   assign bus.uart_addr_o      = addr_q;
   assign bus.uart_wren_o      = wren_q;
   assign bus.uart_rden_o      = rden_q;
   assign bus.uart_din_o       = din_q;
   assign bus.grant_o          = grant_q;
endmodule
